// File: rtl/kernel_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kernel_fetch_pkg
// Purpose  : Shared constants and FSM state encoding for the kernel fetch
//            read sequencer and its beat FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package kernel_fetch_pkg;

    // Kernel memory address width: {row, bank, col[2:0], word[2:0]}
    localparam int KMEM_ADDR_WIDTH      = 12;

    // One row holds 8 columns x 8 words per bank
    localparam int KFETCH_BEATS_PER_ROW = 64;

    // Output beat buffer depth; also the cap on outstanding reads
    localparam int KFETCH_FIFO_DEPTH    = 4;

    // Width of one bank read word
    localparam int KFETCH_WORD_W        = 64;

    // Sequencer states
    typedef enum logic [1:0] {
        KF_IDLE  = 2'd0,
        KF_FETCH = 2'd1,
        KF_DRAIN = 2'd2
    } kf_state_e;

endpackage : kernel_fetch_pkg
`default_nettype wire

// File: rtl/kfetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : kfetch_fifo
// Purpose  : Small synchronous FIFO holding merged kernel beats plus their
//            last-flag. Head entry is presented combinationally; occupancy
//            count is exported so the sequencer can cap outstanding reads.
// Revision : 1.0 - initial release
// ============================================================================
module kfetch_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_pop;
    logic               w_do_push;

    // Popping an empty FIFO is a no-op; the sequencer never pushes when full
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && (r_count != c_cnt_w'(DEPTH));

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule : kfetch_fifo
`default_nettype wire

// File: rtl/kernel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : kernel_fetch
// Purpose  : Read sequencer for kernel_sram. Walks rows of the kernel memory,
//            reading bank 0 and bank 1 in lockstep, merges each pair of 64-bit
//            words into a 128-bit beat and streams it over valid/ready.
//            Issue stalls while the loader writes and whenever 4 beats are
//            already outstanding.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_fetch
    import kernel_fetch_pkg::*;
#(
    parameter int AW = KMEM_ADDR_WIDTH,
    parameter int RW = AW - 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [RW-1:0]              cfg_row_base,
    input  logic [RW-1:0]              cfg_row_num,
    input  logic                       wr_busy,
    output logic                       ren1,
    output logic [AW-1:0]              ra1,
    output logic                       ren2,
    output logic [AW-1:0]              ra2,
    input  logic [KFETCH_WORD_W-1:0]   rd1,
    input  logic [KFETCH_WORD_W-1:0]   rd2,
    output logic                       kvalid,
    output logic [2*KFETCH_WORD_W-1:0] kdata,
    output logic                       klast,
    input  logic                       kready,
    output logic                       busy,
    output logic                       done
);

    localparam int c_beat_w = $clog2(KFETCH_BEATS_PER_ROW);
    localparam int c_cnt_w  = $clog2(KFETCH_FIFO_DEPTH + 1);
    localparam int c_fifo_w = 2 * KFETCH_WORD_W + 1;

    kf_state_e             r_state;
    logic [RW-1:0]         r_row;
    logic [RW-1:0]         r_rows_left;
    logic [c_beat_w-1:0]   r_beat;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_row_end;
    logic                  w_last_addr;
    logic                  w_pop;
    logic [c_cnt_w-1:0]    w_fifo_count;
    logic [c_cnt_w-1:0]    w_outstanding;
    logic [c_fifo_w-1:0]   w_head;

    // A start landing on the done pulse is ignored; it is taken one cycle later
    assign w_accept      = (r_state == KF_IDLE) && start && !r_done;

    // Beats buffered plus the read whose data arrives next cycle
    assign w_outstanding = w_fifo_count + c_cnt_w'(r_inflight);

    // Only registered state and wr_busy feed issue, so kready never reaches ren*
    assign w_issue       = (r_state == KF_FETCH) && (r_rows_left != '0) && !wr_busy &&
                           (w_outstanding < c_cnt_w'(KFETCH_FIFO_DEPTH));

    assign w_row_end     = (r_beat == c_beat_w'(KFETCH_BEATS_PER_ROW - 1));
    assign w_last_addr   = w_row_end && (r_rows_left == RW'(1));

    assign w_pop         = kvalid && kready;

    // Sequencer FSM with row/beat address counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= KF_IDLE;
            r_row           <= '0;
            r_rows_left     <= '0;
            r_beat          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_last_addr;
            case (r_state)
                KF_IDLE: begin
                    if (w_accept) begin
                        r_row       <= cfg_row_base;
                        r_rows_left <= cfg_row_num;
                        r_beat      <= '0;
                        r_state     <= KF_FETCH;
                    end
                end
                KF_FETCH: begin
                    if (r_rows_left == '0) begin
                        // Empty job: nothing to read, finish straight away
                        r_state <= KF_IDLE;
                        r_done  <= 1'b1;
                    end else if (w_issue) begin
                        if (w_last_addr) begin
                            r_state <= KF_DRAIN;
                        end else begin
                            r_beat <= r_beat + c_beat_w'(1);
                            if (w_row_end) begin
                                // Row arithmetic wraps modulo 2^RW
                                r_row       <= r_row + RW'(1);
                                r_rows_left <= r_rows_left - RW'(1);
                            end
                        end
                    end
                end
                KF_DRAIN: begin
                    if (w_pop && klast) begin
                        r_state <= KF_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= KF_IDLE;
                end
            endcase
        end
    end

    kfetch_fifo #(
        .WIDTH (c_fifo_w),
        .DEPTH (KFETCH_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data ({rd2, rd1, r_inflight_last}),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_fifo_count)
    );

    assign ren1   = w_issue;
    assign ren2   = w_issue;
    assign ra1    = {r_row, 1'b0, r_beat};
    assign ra2    = {r_row, 1'b1, r_beat};

    assign kvalid = (w_fifo_count != '0);
    assign kdata  = w_head[c_fifo_w-1:1];
    assign klast  = kvalid && w_head[0];

    assign busy   = (r_state != KF_IDLE);
    assign done   = r_done;

endmodule : kernel_fetch
`default_nettype wire
